spi_burst_sequencer: RTL
========================

Name: spi_burst_sequencer

Overview:
- Sits directly upstream of the single-word SPI master and turns a multi-word command into back-to-back single-word transfers.
- Buffers outgoing words in a TX FIFO and drives the master's start/mosi_data handshake one word at a time.
- Collects each received word from the master's miso_data/done into an RX FIFO for the host side.

Parameters:
DATA_WIDTH, 8, word width; must equal the SPI master's DATA_WIDTH
FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; power of 2, >=2
MAX_LEN, 16, largest legal burst length in words; LEN_W = $clog2(MAX_LEN+1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
cmd_valid  in  1  burst command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_len  in  LEN_W  words in the burst
tx_valid  in  1  TX word valid
tx_ready  out  1  TX FIFO not full
tx_data  in  DATA_WIDTH  word to transmit
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  host pops RX head
rx_data  out  DATA_WIDTH  RX FIFO head (first-word-fall-through)
busy  out  1  burst in progress
txn_done  out  1  1-cycle pulse at burst end
txn_err  out  1  1-cycle pulse when cmd_len > MAX_LEN
spi_start  out  1  to master start
spi_mosi_data  out  DATA_WIDTH  to master mosi_data
spi_miso_data  in  DATA_WIDTH  from master miso_data
spi_done  in  1  from master done

Behaviour:
- Reset values: state S_IDLE, both FIFOs empty, remaining counter 0, spi_start 0, spi_mosi_data 0, txn_done 0, txn_err 0. Derived outputs after reset: cmd_ready 1, tx_ready 1, rx_valid 0, busy 0. Reset mid-burst discards all FIFO contents and in-flight state with no partial txn_done.
- TX FIFO: push when tx_valid && tx_ready. Pop only in S_WAIT. Pop and push in the same cycle are both honoured. Never pops when empty.
- RX FIFO: pop when rx_valid && rx_ready. Push only in S_XFER. rx_data is valid whenever rx_valid is 1. Simultaneous push and pop leave the count unchanged.
- Master contract: the master samples start only while idle and holds done=1 until start falls. Its done stays high one further cycle after returning to idle. A new start is therefore issued only after done is observed low.
- FSM, all outputs registered:
  - S_IDLE: cmd_ready=1. On an accepted command:
    - cmd_len==0: txn_done pulses next cycle; stay in S_IDLE.
    - cmd_len>MAX_LEN: txn_err pulses next cycle; stay in S_IDLE.
    - Otherwise: remaining<=cmd_len, go to S_WAIT.
  - S_WAIT: when TX is non-empty AND RX count < FIFO_DEPTH: pop TX head into spi_mosi_data, spi_start<=1, go to S_XFER. Otherwise stall indefinitely.
  - S_XFER: when spi_done==1: push spi_miso_data into RX, spi_start<=0, remaining<=remaining-1, go to S_REL. RX space is guaranteed by the S_WAIT check, since only this block pushes.
  - S_REL: when spi_done==0: if remaining==0, txn_done<=1 and go to S_IDLE; else go to S_WAIT.
- busy=1 in every state except S_IDLE. cmd_ready=0 while busy.
- Latency: spi_start rises 1 cycle after S_WAIT's conditions are met. The RX word is visible on rx_data 1 cycle after spi_done is seen high.
- Word order is preserved: the k-th TX word popped pairs with the k-th RX word pushed.
- Pointers wrap modulo FIFO_DEPTH. Counts are $clog2(FIFO_DEPTH)+1 bits wide.

Test Plan:
- Reset, then tx 0xA5, cmd_len=1, loopback slave (miso=mosi) -> one spi_start, rx_data=0xA5, txn_done pulses once, busy returns to 0.
- Preload 4 words 0x01..0x04, cmd_len=4, slave returns ~mosi -> rx order 0xFE,0xFD,0xFC,0xFB; spi_start never high while spi_done is high from the prior word.
- cmd_len=3 with TX initially empty, words trickled in 50 cycles apart -> sequencer stalls in S_WAIT, 3 transfers occur, then txn_done.
- rx_ready=0, cmd_len=10, DEPTH=8 -> exactly 8 transfers then stall. Raising rx_ready resumes the last 2; no RX data is lost.
- cmd_len=0 -> txn_done pulse, no spi_start. cmd_len=17 -> txn_err pulse, no spi_start.
- rst asserted during the 2nd word of a 4-word burst -> all outputs at reset values immediately, FIFOs empty, no txn_done.

Source files
------------

// File: rtl/spi_burst_sequencer_if.sv
// Host-side command/TX/RX handshakes and the single-word SPI master handshake
// seen by spi_burst_sequencer. The sequencer uses the slave modport.
interface spi_burst_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 5
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_W-1:0]      cmd_len;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  txn_done;
  logic                  txn_err;
  logic                  spi_start;
  logic [DATA_WIDTH-1:0] spi_mosi_data;
  logic [DATA_WIDTH-1:0] spi_miso_data;
  logic                  spi_done;

  modport slave (
    input  cmd_valid, cmd_len, tx_valid, tx_data, rx_ready, spi_miso_data, spi_done,
    output cmd_ready, tx_ready, rx_valid, rx_data, busy, txn_done, txn_err,
           spi_start, spi_mosi_data
  );

  modport master (
    output cmd_valid, cmd_len, tx_valid, tx_data, rx_ready, spi_miso_data, spi_done,
    input  cmd_ready, tx_ready, rx_valid, rx_data, busy, txn_done, txn_err,
           spi_start, spi_mosi_data
  );
endinterface

// File: rtl/spi_burst_sequencer.sv
// Splits a multi-word burst command into back-to-back single-word SPI master
// transfers, with TX and RX word FIFOs on the host side.
module spi_burst_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  spi_burst_sequencer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [LEN_W-1:0]      remaining_r, remaining_nxt_s;
  logic                  spi_start_r, spi_start_nxt_s;
  logic [DATA_WIDTH-1:0] mosi_r, mosi_nxt_s;
  logic                  txn_done_r, txn_done_nxt_s;
  logic                  txn_err_r, txn_err_nxt_s;

  logic [DATA_WIDTH-1:0] tx_mem_r [FIFO_DEPTH];
  logic [AW-1:0]         tx_wr_r, tx_rd_r;
  logic [CW-1:0]         tx_cnt_r;
  logic [DATA_WIDTH-1:0] rx_mem_r [FIFO_DEPTH];
  logic [AW-1:0]         rx_wr_r, rx_rd_r;
  logic [CW-1:0]         rx_cnt_r;

  logic tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;

  assign tx_push_s = bus.tx_valid && (tx_cnt_r != CW'(FIFO_DEPTH));
  assign rx_pop_s  = bus.rx_ready && (rx_cnt_r != {CW{1'b0}});

  assign bus.cmd_ready     = (state_r == S_IDLE);
  assign bus.busy          = (state_r != S_IDLE);
  assign bus.tx_ready      = (tx_cnt_r != CW'(FIFO_DEPTH));
  assign bus.rx_valid      = (rx_cnt_r != {CW{1'b0}});
  assign bus.rx_data       = rx_mem_r[rx_rd_r];
  assign bus.spi_start     = spi_start_r;
  assign bus.spi_mosi_data = mosi_r;
  assign bus.txn_done      = txn_done_r;
  assign bus.txn_err       = txn_err_r;

  // Storage arrays; contents are don't-care while the matching count is zero.
  always_ff @(posedge clk) begin
    if (tx_push_s) begin
      tx_mem_r[tx_wr_r] <= bus.tx_data;
    end
    if (rx_push_s) begin
      rx_mem_r[rx_wr_r] <= bus.spi_miso_data;
    end
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_r  <= {AW{1'b0}};
      tx_rd_r  <= {AW{1'b0}};
      tx_cnt_r <= {CW{1'b0}};
    end else begin
      if (tx_push_s) tx_wr_r <= tx_wr_r + AW'(1);
      if (tx_pop_s)  tx_rd_r <= tx_rd_r + AW'(1);
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_r <= tx_cnt_r + CW'(1);
        2'b01:   tx_cnt_r <= tx_cnt_r - CW'(1);
        default: tx_cnt_r <= tx_cnt_r;
      endcase
    end
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_r  <= {AW{1'b0}};
      rx_rd_r  <= {AW{1'b0}};
      rx_cnt_r <= {CW{1'b0}};
    end else begin
      if (rx_push_s) rx_wr_r <= rx_wr_r + AW'(1);
      if (rx_pop_s)  rx_rd_r <= rx_rd_r + AW'(1);
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_r <= rx_cnt_r + CW'(1);
        2'b01:   rx_cnt_r <= rx_cnt_r - CW'(1);
        default: rx_cnt_r <= rx_cnt_r;
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      remaining_r <= {LEN_W{1'b0}};
      spi_start_r <= 1'b0;
      mosi_r      <= {DATA_WIDTH{1'b0}};
      txn_done_r  <= 1'b0;
      txn_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      remaining_r <= remaining_nxt_s;
      spi_start_r <= spi_start_nxt_s;
      mosi_r      <= mosi_nxt_s;
      txn_done_r  <= txn_done_nxt_s;
      txn_err_r   <= txn_err_nxt_s;
    end
  end

  // Next-state decode; a new start only follows done being seen low in S_REL.
  always_comb begin
    state_nxt_s     = state_r;
    remaining_nxt_s = remaining_r;
    spi_start_nxt_s = spi_start_r;
    mosi_nxt_s      = mosi_r;
    txn_done_nxt_s  = 1'b0;
    txn_err_nxt_s   = 1'b0;
    tx_pop_s        = 1'b0;
    rx_push_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_len == {LEN_W{1'b0}}) begin
            txn_done_nxt_s = 1'b1;
          end else if (bus.cmd_len > LEN_W'(MAX_LEN)) begin
            txn_err_nxt_s = 1'b1;
          end else begin
            remaining_nxt_s = bus.cmd_len;
            state_nxt_s     = S_WAIT;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        // Reserving RX space here is what lets S_XFER push unconditionally.
        if ((tx_cnt_r != {CW{1'b0}}) && (rx_cnt_r < CW'(FIFO_DEPTH))) begin
          tx_pop_s        = 1'b1;
          mosi_nxt_s      = tx_mem_r[tx_rd_r];
          spi_start_nxt_s = 1'b1;
          state_nxt_s     = S_XFER;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_XFER: begin
        if (bus.spi_done) begin
          rx_push_s       = 1'b1;
          spi_start_nxt_s = 1'b0;
          remaining_nxt_s = remaining_r - LEN_W'(1);
          state_nxt_s     = S_REL;
        end else begin
          state_nxt_s = S_XFER;
        end
      end
      S_REL: begin
        if (!bus.spi_done) begin
          if (remaining_r == {LEN_W{1'b0}}) begin
            txn_done_nxt_s = 1'b1;
            state_nxt_s    = S_IDLE;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end else begin
          state_nxt_s = S_REL;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end
endmodule
